cpu_sequencer: RTL and testbench
================================

Name: cpu_sequencer

Overview:
- Instruction-driven control unit for the 4-register processing unit datapath (register file, unit function block, MB/MD muxes, registered flags).
- Accepts encoded instructions over a valid/ready handshake and emits the 14-bit control word, packed as {FS[4:0], A[1:0], B[1:0], D[1:0], MB_S, MD_S, Write}, cycle by cycle.
- Sequences multi-cycle operations: external load, external store, repeated ALU op, flag-conditional skip, halt.
- Sits between the instruction source and the datapath; consumes the datapath's registered flags.

Parameters:
- N, 4, datapath data width; also immediate/repeat-count width.
- IW, 14+N, instruction width.
- Z_BIT, 0, index of the zero flag within flags_in.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- instr_valid  in  1  instruction offered.
- instr  in  IW  {op[2:0], fs[4:0], d[1:0], a[1:0], b[1:0], imm[N-1:0]}, MSB first.
- instr_ready  out  1  instruction accepted when valid&&ready at a clock edge.
- ld_valid  in  1  external data present on the datapath data input.
- ld_ready  out  1  sequencer waiting for load data.
- st_valid  out  1  datapath data/address outputs hold a store.
- st_ready  in  1  store consumer accepts.
- flags_in  in  N  registered datapath flags.
- ctrl_word  out  14  datapath control word.
- const_out  out  N  constant-input value for MB_S=1.
- halted  out  1  HALT executed.

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=FETCH; ctrl_word=0; const_out=0; counter=0; skip_pending=0.
  - st_valid=0, halted=0, ld_ready=0; instr_ready=1 from the first cycle after reset.
  - Reset mid-operation aborts any pending load, store or repeat with no further Write.
- States: FETCH, LOAD_W, STORE_W, REP, FLAG_W, HALT.
- instr_ready=1 only in FETCH. ctrl_word and const_out are registered, except the Write bit in LOAD_W, which equals ld_valid combinationally.
- Any cycle with no instruction accepted and no multi-cycle op active: ctrl_word=0 (Write=0).
- Opcodes, decoded on the accept edge; the resulting ctrl_word is valid in the following cycle:
  - 0 NOP: ctrl_word=0; stay in FETCH.
  - 1 ALU_RR: {fs,a,b,d,0,0,1} for exactly one cycle; stay in FETCH. Throughput is 1 instruction/cycle.
  - 2 ALU_RI: {fs,a,b,d,1,0,1}; const_out=imm for that cycle; stay in FETCH.
  - 3 LOAD: go to LOAD_W. ctrl_word={fs,a,b,d,0,1,W}, ld_ready=1. W=ld_valid. On ld_valid the register is written in that same cycle; return to FETCH.
  - 4 STORE: go to STORE_W. ctrl_word={fs,a,b,d,0,0,0}, st_valid=1, both held stable until st_ready is sampled high. Then st_valid=0, return to FETCH.
  - 5 REP: imm=0 behaves as NOP. Otherwise go to REP with counter=imm. ctrl_word={fs,a,b,d,0,0,1} for exactly imm consecutive cycles; counter decrements each cycle; exit to FETCH after the cycle where counter=1. imm=2^N-1 gives the maximum count.
  - 6 SKIPZ: go to FLAG_W for one cycle with ctrl_word=0. In that cycle flags_in reflects the ALU op issued in the cycle before the SKIPZ accept. If flags_in[Z_BIT]=1, set skip_pending. Return to FETCH.
  - 7 HALT: go to HALT. ctrl_word=0, halted=1, instr_ready=0; only reset exits.
- skip_pending=1:
  - The next accepted instruction is consumed with instr_ready=1 but not executed: ctrl_word=0, no state change, including HALT, SKIPZ and REP.
  - skip_pending then clears.
  - Two SKIPZ in a row: the second is skipped only if the first found Z=1.
- ld_valid or st_ready asserted outside their wait states is ignored.

Decomposition:
- Package cpu_seq_pkg:
  - opcode enum (NOP..HALT);
  - state enum;
  - instruction field position constants;
  - ctrl_word bit-position constants;
  - a pack_ctrl function building the 14-bit word.
- Optional combinational sub-module cpu_seq_decode: instr -> fields plus a next-state class.
- FSM, counter, skip logic and output registers stay in cpu_sequencer.

Test Plan:
- Reset then ALU_RR fs=5'h02,a=1,b=2,d=3: next cycle ctrl_word={02,1,2,3,0,0,1}, one cycle only. Back-to-back ALU_RI imm=4'h9: following cycle MB_S=1, const_out=9.
- LOAD d=2, ld_valid held low 3 cycles then high: ld_ready=1 for 4 cycles; Write=0,0,0,1 with MD_S=1,D=2; then FETCH.
- STORE a=1,b=0, st_ready low 2 cycles: st_valid=1 and ctrl_word constant for 3 cycles, Write=0 throughout; st_valid=0 after acceptance.
- REP imm=3: Write=1 exactly 3 cycles, instr_ready=0 meanwhile. REP imm=0: no Write, instr_ready stays 1. REP imm=15: 15 Write cycles.
- ALU op producing zero, then SKIPZ with flags_in[0]=1, then ALU_RR: ALU_RR accepted but ctrl_word=0. Repeat with flags_in[0]=0: ALU_RR executes.
- rst_n low during REP counter=5 and, separately, during STORE_W: next cycle ctrl_word=0, st_valid=0, FETCH. HALT: halted=1, instr_ready=0 until rst_n.

Source files
------------

// File: rtl/cpu_seq_pkg.sv
// cpu_seq_pkg
//   Shared definitions for the instruction sequencer of the 4-register
//   processing unit: opcode and FSM state enums, instruction field offsets,
//   control-word bit positions and the control-word packing helper.
//   No ports (package).
package cpu_seq_pkg;

  // Control word layout: {FS[4:0], A[1:0], B[1:0], D[1:0], MB_S, MD_S, Write}
  localparam int CW_W      = 14;
  localparam int CW_WRITE  = 0;
  localparam int CW_MD_S   = 1;
  localparam int CW_MB_S   = 2;
  localparam int CW_D_LSB  = 3;
  localparam int CW_B_LSB  = 5;
  localparam int CW_A_LSB  = 7;
  localparam int CW_FS_LSB = 9;

  // Instruction layout {op, fs, d, a, b, imm}: offsets are measured from the
  // bit just above the N-bit immediate, so they hold for any data width.
  localparam int IF_B_OFS  = 0;
  localparam int IF_A_OFS  = 2;
  localparam int IF_D_OFS  = 4;
  localparam int IF_FS_OFS = 6;
  localparam int IF_OP_OFS = 11;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_ALU_RR = 3'd1,
    OP_ALU_RI = 3'd2,
    OP_LOAD   = 3'd3,
    OP_STORE  = 3'd4,
    OP_REP    = 3'd5,
    OP_SKIPZ  = 3'd6,
    OP_HALT   = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_LOAD_W  = 3'd1,
    ST_STORE_W = 3'd2,
    ST_REP     = 3'd3,
    ST_FLAG_W  = 3'd4,
    ST_HALT    = 3'd5
  } state_e;

  function automatic logic [CW_W-1:0] pack_ctrl(
    input logic [4:0] fs,
    input logic [1:0] a,
    input logic [1:0] b,
    input logic [1:0] d,
    input logic       mb_s,
    input logic       md_s,
    input logic       wr
  );
    logic [CW_W-1:0] w;
    w                    = '0;
    w[CW_FS_LSB +: 5]    = fs;
    w[CW_A_LSB  +: 2]    = a;
    w[CW_B_LSB  +: 2]    = b;
    w[CW_D_LSB  +: 2]    = d;
    w[CW_MB_S]           = mb_s;
    w[CW_MD_S]           = md_s;
    w[CW_WRITE]          = wr;
    return w;
  endfunction

endpackage

// File: rtl/cpu_seq_decode.sv
// cpu_seq_decode
//   Purely combinational instruction decoder. Splits an instruction into its
//   fields and reports what the sequencer should do if it executes it.
//   Ports:
//     instr      in   IW  encoded instruction {op, fs, d, a, b, imm}
//     next_state out      FSM state to enter after the accept edge
//     ctrl       out  14  control word to present in the following cycle
//     const_val  out  N   constant-input value for the following cycle
//     count      out  N   repeat count (REP only, else 0)
module cpu_seq_decode
  import cpu_seq_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 14 + N
) (
  input  logic [IW-1:0]   instr,
  output state_e          next_state,
  output logic [CW_W-1:0] ctrl,
  output logic [N-1:0]    const_val,
  output logic [N-1:0]    count
);

  opcode_e      op;
  logic [4:0]   fs;
  logic [1:0]   a;
  logic [1:0]   b;
  logic [1:0]   d;
  logic [N-1:0] imm;

  assign op  = opcode_e'(instr[N+IF_OP_OFS +: 3]);
  assign fs  = instr[N+IF_FS_OFS +: 5];
  assign d   = instr[N+IF_D_OFS  +: 2];
  assign a   = instr[N+IF_A_OFS  +: 2];
  assign b   = instr[N+IF_B_OFS  +: 2];
  assign imm = instr[N-1:0];

  always_comb begin
    next_state = ST_FETCH;
    ctrl       = '0;
    const_val  = '0;
    count      = '0;
    case (op)
      OP_ALU_RR: ctrl = pack_ctrl(fs, a, b, d, 1'b0, 1'b0, 1'b1);
      OP_ALU_RI: begin
        ctrl      = pack_ctrl(fs, a, b, d, 1'b1, 1'b0, 1'b1);
        const_val = imm;
      end
      OP_LOAD: begin
        // Write is overridden by ld_valid while waiting for the data
        ctrl       = pack_ctrl(fs, a, b, d, 1'b0, 1'b1, 1'b0);
        next_state = ST_LOAD_W;
      end
      OP_STORE: begin
        ctrl       = pack_ctrl(fs, a, b, d, 1'b0, 1'b0, 1'b0);
        next_state = ST_STORE_W;
      end
      OP_REP: begin
        // A zero count degenerates to a NOP
        if (imm != '0) begin
          ctrl       = pack_ctrl(fs, a, b, d, 1'b0, 1'b0, 1'b1);
          count      = imm;
          next_state = ST_REP;
        end
      end
      OP_SKIPZ: next_state = ST_FLAG_W;
      OP_HALT:  next_state = ST_HALT;
      default:  ;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer
//   Instruction-driven control unit for the 4-register processing unit.
//   Accepts instructions on a valid/ready handshake and drives the datapath
//   control word cycle by cycle, sequencing load, store, repeat, skip and
//   halt operations.
//   Ports:
//     clk, rst_n          clock (rising edge), synchronous active-low reset
//     instr_valid/instr   instruction offer; instr_ready accepts (FETCH only)
//     ld_valid/ld_ready   external load data handshake
//     st_valid/st_ready   store handshake
//     flags_in            registered datapath flags (zero flag at Z_BIT)
//     ctrl_word           {FS, A, B, D, MB_S, MD_S, Write}
//     const_out           constant input used when MB_S=1
//     halted              HALT executed, only reset leaves
module cpu_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int N     = 4,
  parameter int IW    = 14 + N,
  parameter int Z_BIT = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  input  logic [IW-1:0]   instr,
  output logic            instr_ready,
  input  logic            ld_valid,
  output logic            ld_ready,
  output logic            st_valid,
  input  logic            st_ready,
  input  logic [N-1:0]    flags_in,
  output logic [CW_W-1:0] ctrl_word,
  output logic [N-1:0]    const_out,
  output logic            halted
);

  state_e          state_q, state_d;
  logic [CW_W-1:0] ctrl_q, ctrl_d;
  logic [N-1:0]    const_q, const_d;
  logic [N-1:0]    counter_q, counter_d;
  logic            skip_q, skip_d;

  state_e          dec_state;
  logic [CW_W-1:0] dec_ctrl;
  logic [N-1:0]    dec_const;
  logic [N-1:0]    dec_count;

  // Only the zero flag steers sequencing; the other flags pass by.
  logic unused_flags;
  assign unused_flags = ^flags_in;

  cpu_seq_decode #(
    .N  (N),
    .IW (IW)
  ) u_decode (
    .instr      (instr),
    .next_state (dec_state),
    .ctrl       (dec_ctrl),
    .const_val  (dec_const),
    .count      (dec_count)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      ctrl_q    <= '0;
      const_q   <= '0;
      counter_q <= '0;
      skip_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      const_q   <= const_d;
      counter_q <= counter_d;
      skip_q    <= skip_d;
    end
  end

  // Next-state and next-register logic
  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    const_d   = '0;
    counter_d = counter_q;
    skip_d    = skip_q;
    case (state_q)
      ST_FETCH: begin
        ctrl_d = '0;
        if (instr_valid) begin
          if (skip_q) begin
            // Consume the instruction without executing it
            skip_d = 1'b0;
          end else begin
            state_d   = dec_state;
            ctrl_d    = dec_ctrl;
            const_d   = dec_const;
            counter_d = dec_count;
          end
        end
      end
      ST_LOAD_W: begin
        if (ld_valid) begin
          state_d = ST_FETCH;
          ctrl_d  = '0;
        end
      end
      ST_STORE_W: begin
        if (st_ready) begin
          state_d = ST_FETCH;
          ctrl_d  = '0;
        end
      end
      ST_REP: begin
        // counter holds the number of Write cycles left including this one
        if (counter_q == N'(1)) begin
          state_d   = ST_FETCH;
          ctrl_d    = '0;
          counter_d = '0;
        end else begin
          counter_d = counter_q - N'(1);
        end
      end
      ST_FLAG_W: begin
        state_d = ST_FETCH;
        ctrl_d  = '0;
        if (flags_in[Z_BIT]) skip_d = 1'b1;
      end
      ST_HALT: begin
        ctrl_d = '0;
      end
      default: begin
        state_d = ST_FETCH;
        ctrl_d  = '0;
      end
    endcase
  end

  // Outputs
  always_comb begin
    instr_ready = 1'b0;
    ld_ready    = 1'b0;
    st_valid    = 1'b0;
    halted      = 1'b0;
    ctrl_word   = ctrl_q;
    const_out   = const_q;
    case (state_q)
      ST_FETCH:   instr_ready = 1'b1;
      ST_LOAD_W: begin
        ld_ready            = 1'b1;
        // Register write happens in the same cycle the data shows up
        ctrl_word[CW_WRITE] = ld_valid;
      end
      ST_STORE_W: st_valid = 1'b1;
      ST_HALT:    halted   = 1'b1;
      default:    ;
    endcase
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer
//   Scoreboard bench for cpu_sequencer. The driver expands each instruction
//   into the per-cycle responses the instruction set promises and queues
//   them; a monitor pops one expectation per cycle at the falling edge.
module tb_cpu_sequencer;

  localparam int N  = 4;
  localparam int IW = 14 + N;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          instr_valid = 1'b0;
  logic [IW-1:0] instr = '0;
  logic          instr_ready;
  logic          ld_valid = 1'b0;
  logic          ld_ready;
  logic          st_valid;
  logic          st_ready = 1'b0;
  logic [N-1:0]  flags_in = '0;
  logic [13:0]   ctrl_word;
  logic [N-1:0]  const_out;
  logic          halted;

  cpu_sequencer #(.N(N), .IW(IW), .Z_BIT(0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .st_valid    (st_valid),
    .st_ready    (st_ready),
    .flags_in    (flags_in),
    .ctrl_word   (ctrl_word),
    .const_out   (const_out),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         rdy;
    logic         ldr;
    logic         stv;
    logic         hlt;
    logic         cchk;
    logic [13:0]  ctrl;
    logic [N-1:0] cst;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    total = 0;
  int    bad   = 0;
  bit    mon_on = 0;
  int    cyc = 0;

  // Architectural model state
  logic [13:0]  carry_ctrl = '0;
  logic [N-1:0] carry_const = '0;
  bit           skip_m = 0;
  bit           rst_chk = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [13:0] mk(input logic [4:0] fs, input logic [1:0] a,
                                     input logic [1:0] b, input logic [1:0] d,
                                     input logic mb, input logic md, input logic w);
    return {fs, a, b, d, mb, md, w};
  endfunction

  // Monitor: one observation per cycle
  always @(negedge clk) begin
    if (mon_on) begin
      exp_t  e;
      string t;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL underflow cyc=%0d got ctrl=%h rdy=%b (no expectation queued)",
                 cyc, ctrl_word, instr_ready);
      end else begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        if (instr_ready !== e.rdy || ld_ready !== e.ldr || st_valid !== e.stv ||
            halted !== e.hlt || ctrl_word !== e.ctrl ||
            (e.cchk && const_out !== e.cst)) begin
          bad++;
          $display("FAIL %s cyc=%0d got rdy=%b ldr=%b stv=%b hlt=%b ctrl=%h const=%h want rdy=%b ldr=%b stv=%b hlt=%b ctrl=%h const=%h(chk=%b)",
                   t, cyc, instr_ready, ld_ready, st_valid, halted, ctrl_word, const_out,
                   e.rdy, e.ldr, e.stv, e.hlt, e.ctrl, e.cst, e.cchk);
        end
      end
    end
  end

  task automatic push(input logic rdy, input logic ldr, input logic stv, input logic hlt,
                      input logic cchk, input logic [13:0] ctrl, input logic [N-1:0] cst,
                      input string tag);
    exp_t e;
    e = '{rdy: rdy, ldr: ldr, stv: stv, hlt: hlt, cchk: cchk, ctrl: ctrl, cst: cst};
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Random activity on inputs that must be ignored in the current cycle
  task automatic noise();
    ld_valid = 1'($urandom);
    st_ready = 1'($urandom);
    flags_in = N'($urandom);
  endtask

  task automatic busy_in();
    instr_valid = 1'($urandom);
    instr       = IW'($urandom);
  endtask

  task automatic post_reset();
    rst_n       = 1'b1;
    carry_ctrl  = '0;
    carry_const = '0;
    skip_m      = 0;
    rst_chk     = 1;
  endtask

  task automatic idle(input string tag);
    noise();
    instr_valid = 1'b0;
    instr       = IW'($urandom);
    push(1'b1, 1'b0, 1'b0, 1'b0, carry_ctrl[2] | rst_chk, carry_ctrl, carry_const, tag);
    rst_chk     = 0;
    carry_ctrl  = '0;
    carry_const = '0;
    tick();
  endtask

  // Issue one instruction and queue the responses it must produce.
  // stall: wait cycles for LOAD/STORE, extra cycles for HALT before reset.
  // abort_at: wait/repeat cycle index in which reset is pulsed (-1 = none).
  task automatic issue(input logic [2:0] op, input logic [4:0] fs, input logic [1:0] a,
                       input logic [1:0] b, input logic [1:0] d, input logic [N-1:0] imm,
                       input int stall, input int abort_at, input bit zflag);
    noise();
    instr_valid = 1'b1;
    instr       = {op, fs, d, a, b, imm};
    push(1'b1, 1'b0, 1'b0, 1'b0, carry_ctrl[2] | rst_chk, carry_ctrl, carry_const, "accept");
    $display("issue op=%0d fs=%h a=%0d b=%0d d=%0d imm=%0d stall=%0d abort=%0d z=%0b skipped=%0b",
             op, fs, a, b, d, imm, stall, abort_at, zflag, skip_m);
    rst_chk     = 0;
    carry_ctrl  = '0;
    carry_const = '0;
    tick();
    if (skip_m) begin
      skip_m = 0;
      return;
    end
    case (op)
      3'd1: carry_ctrl = mk(fs, a, b, d, 1'b0, 1'b0, 1'b1);
      3'd2: begin
        carry_ctrl  = mk(fs, a, b, d, 1'b1, 1'b0, 1'b1);
        carry_const = imm;
      end
      3'd3: begin
        for (int i = 0; i <= stall; i++) begin
          noise(); busy_in();
          ld_valid = (i == stall);
          if (i == abort_at) rst_n = 1'b0;
          push(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, mk(fs, a, b, d, 1'b0, 1'b1, (i == stall)), '0, "load");
          tick();
          if (i == abort_at) begin post_reset(); return; end
        end
      end
      3'd4: begin
        for (int i = 0; i <= stall; i++) begin
          noise(); busy_in();
          st_ready = (i == stall) && (i != abort_at);
          if (i == abort_at) rst_n = 1'b0;
          push(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, mk(fs, a, b, d, 1'b0, 1'b0, 1'b0), '0, "store");
          tick();
          if (i == abort_at) begin post_reset(); return; end
        end
      end
      3'd5: begin
        for (int i = 0; i < int'(imm); i++) begin
          noise(); busy_in();
          if (i == abort_at) rst_n = 1'b0;
          push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(fs, a, b, d, 1'b0, 1'b0, 1'b1), '0, "rep");
          tick();
          if (i == abort_at) begin post_reset(); return; end
        end
      end
      3'd6: begin
        noise(); busy_in();
        flags_in[0] = zflag;
        push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, "flag");
        tick();
        skip_m = zflag;
      end
      3'd7: begin
        for (int i = 0; i <= stall; i++) begin
          noise(); busy_in();
          if (i == stall) rst_n = 1'b0;
          push(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0, "halt");
          tick();
        end
        post_reset();
      end
      default: ;
    endcase
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d simulation did not complete", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] rop;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    rst_chk = 1;
    mon_on  = 1;
    idle("reset_state");

    // ALU_RR then back-to-back ALU_RI
    issue(3'd1, 5'h02, 2'd1, 2'd2, 2'd3, 4'h0, 0, -1, 1'b0);
    issue(3'd2, 5'h05, 2'd0, 2'd3, 2'd1, 4'h9, 0, -1, 1'b0);
    idle("after_alu_ri");
    idle("idle");
    // LOAD with three empty cycles
    issue(3'd3, 5'h00, 2'd0, 2'd0, 2'd2, 4'h0, 3, -1, 1'b0);
    idle("after_load");
    // STORE with two stalled cycles
    issue(3'd4, 5'h01, 2'd1, 2'd0, 2'd0, 4'h0, 2, -1, 1'b0);
    idle("after_store");
    // REP counts 3, 0, 15
    issue(3'd5, 5'h0A, 2'd2, 2'd1, 2'd0, 4'd3, 0, -1, 1'b0);
    issue(3'd5, 5'h0B, 2'd1, 2'd1, 2'd1, 4'd0, 0, -1, 1'b0);
    issue(3'd5, 5'h0C, 2'd3, 2'd0, 2'd2, 4'd15, 0, -1, 1'b0);
    idle("after_rep");
    // SKIPZ with Z=1 suppresses the following ALU_RR
    issue(3'd1, 5'h03, 2'd1, 2'd1, 2'd1, 4'h0, 0, -1, 1'b0);
    issue(3'd6, 5'h00, 2'd0, 2'd0, 2'd0, 4'h0, 0, -1, 1'b1);
    issue(3'd1, 5'h02, 2'd1, 2'd2, 2'd3, 4'h0, 0, -1, 1'b0);
    idle("after_skip");
    // SKIPZ with Z=0 leaves the ALU_RR alone
    issue(3'd1, 5'h03, 2'd1, 2'd1, 2'd1, 4'h0, 0, -1, 1'b0);
    issue(3'd6, 5'h00, 2'd0, 2'd0, 2'd0, 4'h0, 0, -1, 1'b0);
    issue(3'd1, 5'h02, 2'd1, 2'd2, 2'd3, 4'h0, 0, -1, 1'b0);
    idle("after_noskip");
    // Two SKIPZ in a row: the second is swallowed, the ALU_RR runs
    issue(3'd6, 5'h00, 2'd0, 2'd0, 2'd0, 4'h0, 0, -1, 1'b1);
    issue(3'd6, 5'h00, 2'd0, 2'd0, 2'd0, 4'h0, 0, -1, 1'b1);
    issue(3'd1, 5'h11, 2'd2, 2'd3, 2'd0, 4'h0, 0, -1, 1'b0);
    idle("after_double_skip");
    // A skipped HALT and a skipped REP have no effect
    issue(3'd6, 5'h00, 2'd0, 2'd0, 2'd0, 4'h0, 0, -1, 1'b1);
    issue(3'd7, 5'h00, 2'd0, 2'd0, 2'd0, 4'h0, 2, -1, 1'b0);
    issue(3'd6, 5'h00, 2'd0, 2'd0, 2'd0, 4'h0, 0, -1, 1'b1);
    issue(3'd5, 5'h1F, 2'd3, 2'd3, 2'd3, 4'd7, 0, -1, 1'b0);
    idle("after_skipped_halt");
    // Reset while REP counter is 5, and while waiting in STORE_W
    issue(3'd5, 5'h07, 2'd1, 2'd2, 2'd3, 4'd8, 0, 3, 1'b0);
    idle("after_rep_abort");
    issue(3'd4, 5'h09, 2'd2, 2'd1, 2'd0, 4'h0, 4, 2, 1'b0);
    idle("after_store_abort");
    // HALT held for several cycles with instructions offered, then reset
    issue(3'd7, 5'h00, 2'd0, 2'd0, 2'd0, 4'h0, 3, -1, 1'b0);
    idle("after_halt");

    // Random instruction stream
    repeat (300) begin
      if ($urandom_range(0, 3) == 0) idle("rand_idle");
      rop = 3'($urandom_range(0, 7));
      issue(rop, 5'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), N'($urandom),
            $urandom_range(0, 3), -1, 1'($urandom));
    end
    idle("tail");
    idle("tail");
    mon_on = 0;

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover got %0d unchecked expectations want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
